// File: rtl/int_sequencer.sv
// Interrupt/reset front-end for the 65C02 core: pin sync, reset stretch, NMI/BRK/IRQ arbitration.
// Define NMI_HIJACK_EN to let a late NMI take over a pending IRQ/BRK request.
module int_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned RES_HOLD_CYCLES = 7,
  parameter logic [15:0] VEC_NMI         = 16'hFFFA,
  parameter logic [15:0] VEC_RES         = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ         = 16'hFFFE
) (
  input  logic        PHI_0,
  input  logic        RES,
  input  logic        NMI_PIN,
  input  logic        IRQ_PIN,
  input  logic        I_FLAG,
  input  logic        BRK_REQ,
  input  logic        INST_BOUNDARY,
  input  logic        INT_ACK,
  output logic        CORE_RST_N,
  output logic        INT_REQ,
  output logic [15:0] INT_VEC,
  output logic [1:0]  INT_SRC,
  output logic        B_FLAG
);

  localparam int unsigned    CntW   = $clog2(RES_HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RES_HOLD_CYCLES);

  localparam logic [1:0] SrcNone = 2'b00;
  localparam logic [1:0] SrcRes  = 2'b01;
  localparam logic [1:0] SrcNmi  = 2'b10;
  localparam logic [1:0] SrcIrq  = 2'b11;

  typedef enum logic [1:0] {StHold, StResVec, StIdle, StPend} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, irq_sync_q;
  logic                   nmi_prev_q, nmi_latch_q, nmi_latch_d;
  logic                   brk_pend_q, brk_pend_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic        rst_n_d, req_d, b_d;
  logic [15:0] vec_d;
  logic [1:0]  src_d;

  logic nmi_s, nmi_fall, irq_act, brk_any, ack_pend;

  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign nmi_fall = nmi_prev_q & ~nmi_s;
  assign irq_act  = ~irq_sync_q[SYNC_STAGES-1] & ~I_FLAG;
  // A BRK decoded in the boundary cycle itself is honoured at that boundary.
  assign brk_any  = brk_pend_q | BRK_REQ;
  assign ack_pend = (state_q == StPend) & INT_ACK;

  always_ff @(posedge PHI_0 or negedge RES) begin
    if (!RES) begin
      nmi_sync_q  <= '1;
      irq_sync_q  <= '1;
      nmi_prev_q  <= 1'b1;
      nmi_latch_q <= 1'b0;
      brk_pend_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      nmi_sync_q  <= {nmi_sync_q[SYNC_STAGES-2:0], NMI_PIN};
      irq_sync_q  <= {irq_sync_q[SYNC_STAGES-2:0], IRQ_PIN};
      nmi_prev_q  <= nmi_s;
      nmi_latch_q <= nmi_latch_d;
      brk_pend_q  <= brk_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  // A fresh NMI edge wins over a coincident ack of the previous NMI.
  always_comb begin
    nmi_latch_d = nmi_latch_q;
    if (nmi_fall) begin
      nmi_latch_d = 1'b1;
    end else if (ack_pend && (INT_SRC == SrcNmi)) begin
      nmi_latch_d = 1'b0;
    end
    brk_pend_d = brk_pend_q;
    if (BRK_REQ && ((state_q == StIdle) || (state_q == StPend))) begin
      brk_pend_d = 1'b1;
    end else if (ack_pend && B_FLAG) begin
      brk_pend_d = 1'b0;
    end
    cnt_d = cnt_q;
    if ((state_q == StHold) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge PHI_0 or negedge RES) begin
    if (!RES) begin
      state_q    <= StHold;
      CORE_RST_N <= 1'b0;
      INT_REQ    <= 1'b0;
      INT_VEC    <= VEC_RES;
      INT_SRC    <= SrcRes;
      B_FLAG     <= 1'b0;
    end else begin
      state_q    <= state_d;
      CORE_RST_N <= rst_n_d;
      INT_REQ    <= req_d;
      INT_VEC    <= vec_d;
      INT_SRC    <= src_d;
      B_FLAG     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold:   if (cnt_q == CntMax) state_d = StResVec;
      StResVec: if (INT_ACK) state_d = StIdle;
      StIdle:   if (INST_BOUNDARY && (nmi_latch_q || brk_any || irq_act)) state_d = StPend;
      StPend:   if (INT_ACK) state_d = StIdle;
      default:  state_d = StHold;
    endcase
  end

  always_comb begin
    rst_n_d = CORE_RST_N;
    req_d   = INT_REQ;
    vec_d   = INT_VEC;
    src_d   = INT_SRC;
    b_d     = B_FLAG;
    unique case (state_q)
      StHold: begin
        if (cnt_q == CntMax) begin
          rst_n_d = 1'b1;
          req_d   = 1'b1;
          src_d   = SrcRes;
          vec_d   = VEC_RES;
        end
      end
      StResVec: begin
        if (INT_ACK) begin
          req_d = 1'b0;
          src_d = SrcNone;
        end
      end
      StIdle: begin
        if (INST_BOUNDARY) begin
          if (nmi_latch_q) begin
            req_d = 1'b1;
            src_d = SrcNmi;
            vec_d = VEC_NMI;
            b_d   = 1'b0;
          end else if (brk_any) begin
            req_d = 1'b1;
            src_d = SrcIrq;
            vec_d = VEC_IRQ;
            b_d   = 1'b1;
          end else if (irq_act) begin
            req_d = 1'b1;
            src_d = SrcIrq;
            vec_d = VEC_IRQ;
            b_d   = 1'b0;
          end
        end
      end
      StPend: begin
        if (INT_ACK) begin
          req_d = 1'b0;
          src_d = SrcNone;
          b_d   = 1'b0;
`ifdef NMI_HIJACK_EN
        end else if ((INT_SRC == SrcIrq) && nmi_latch_q) begin
          // B_FLAG is kept so a hijacked BRK still pushes B=1.
          src_d = SrcNmi;
          vec_d = VEC_NMI;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus randomized run against a
// transaction-level model of the request arbitration.
module tb_int_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 7;

  logic        PHI_0 = 1'b0;
  logic        RES = 1'b1;
  logic        NMI_PIN = 1'b1;
  logic        IRQ_PIN = 1'b1;
  logic        I_FLAG = 1'b1;
  logic        BRK_REQ = 1'b0;
  logic        INST_BOUNDARY = 1'b0;
  logic        INT_ACK = 1'b0;
  logic        CORE_RST_N;
  logic        INT_REQ;
  logic [15:0] INT_VEC;
  logic [1:0]  INT_SRC;
  logic        B_FLAG;

  int checks = 0;
  int failures = 0;

  int_sequencer #(
    .SYNC_STAGES    (SYNC),
    .RES_HOLD_CYCLES(HOLD),
    .VEC_NMI        (16'hFFFA),
    .VEC_RES        (16'hFFFC),
    .VEC_IRQ        (16'hFFFE)
  ) dut (
    .PHI_0        (PHI_0),
    .RES          (RES),
    .NMI_PIN      (NMI_PIN),
    .IRQ_PIN      (IRQ_PIN),
    .I_FLAG       (I_FLAG),
    .BRK_REQ      (BRK_REQ),
    .INST_BOUNDARY(INST_BOUNDARY),
    .INT_ACK      (INT_ACK),
    .CORE_RST_N   (CORE_RST_N),
    .INT_REQ      (INT_REQ),
    .INT_VEC      (INT_VEC),
    .INT_SRC      (INT_SRC),
    .B_FLAG       (B_FLAG)
  );

  always #5 PHI_0 = ~PHI_0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PHI_0);
    #1;
  endtask

  task automatic ack_pulse();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
  endtask

  task automatic boundary_pulse();
    INST_BOUNDARY = 1'b1;
    tick();
    INST_BOUNDARY = 1'b0;
  endtask

  task automatic do_reset();
    NMI_PIN = 1'b1; IRQ_PIN = 1'b1; I_FLAG = 1'b1;
    BRK_REQ = 1'b0; INST_BOUNDARY = 1'b0; INT_ACK = 1'b0;
    RES = 1'b0;
    repeat (3) tick();
    RES = 1'b1;
    repeat (HOLD + 1) tick();
    ack_pulse();
    tick();
  endtask

  task automatic test_reset();
    #2 RES = 1'b0;
    repeat (2) tick();
    checks++;
    if ({CORE_RST_N, INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b0, 1'b0, 16'hFFFC, 2'b01, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got rst_n=%b req=%b vec=%h src=%b b=%b, want 0 0 fffc 01 0",
               CORE_RST_N, INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    RES = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      checks++;
      if (CORE_RST_N !== 1'b0 || INT_REQ !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got rst_n=%b req=%b, want 0 0", k, CORE_RST_N, INT_REQ);
      end
    end
    tick();
    checks++;
    if ({CORE_RST_N, INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 1'b1, 16'hFFFC, 2'b01, 1'b0}) begin
      failures++;
      $display("FAIL reset_vector: got rst_n=%b req=%b vec=%h src=%b b=%b, want 1 1 fffc 01 0",
               CORE_RST_N, INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    ack_pulse();
    checks++;
    if ({CORE_RST_N, INT_REQ, INT_SRC} !== {1'b1, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset_ack: got rst_n=%b req=%b src=%b, want 1 0 00", CORE_RST_N, INT_REQ, INT_SRC);
    end
  endtask

  task automatic test_nmi();
    int   reqs;
    int   w;
    logic prev;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        NMI_PIN = 1'b1;
        repeat (10) tick();
      end
      NMI_PIN = 1'b0;
      reqs = 0; w = 0; prev = 1'b0;
      for (int i = 0; i < ((ph == 0) ? 100 : 40); i++) begin
        INST_BOUNDARY = (i % 4 == 0);
        INT_ACK = (w == 1);
        tick();
        if (w > 0) w--;
        if (INT_REQ && !prev) begin
          reqs++;
          w = 2;
          checks++;
          if (INT_VEC !== 16'hFFFA || INT_SRC !== 2'b10 || B_FLAG !== 1'b0) begin
            failures++;
            $display("FAIL nmi_vector: got vec=%h src=%b b=%b, want fffa 10 0", INT_VEC, INT_SRC, B_FLAG);
          end
        end
        prev = INT_REQ;
      end
      INST_BOUNDARY = 1'b0; INT_ACK = 1'b0;
      checks++;
      if (reqs != 1 || INT_REQ !== 1'b0) begin
        failures++;
        $display("FAIL nmi_count phase %0d: got %0d requests (req=%b), want 1 (req=0)", ph, reqs, INT_REQ);
      end
    end
    NMI_PIN = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_irq();
    logic bad;
    IRQ_PIN = 1'b0; I_FLAG = 1'b1; bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      INST_BOUNDARY = (i % 4 == 0);
      tick();
      if (INT_REQ !== 1'b0) bad = 1'b1;
    end
    INST_BOUNDARY = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL irq_masked: got req=1 while I_FLAG=1, want 0");
    end
    I_FLAG = 1'b0;
    tick();
    checks++;
    if (INT_REQ !== 1'b0) begin
      failures++;
      $display("FAIL irq_no_boundary: got req=%b, want 0", INT_REQ);
    end
    boundary_pulse();
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFE, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL irq_request: got req=%b vec=%h src=%b b=%b, want 1 fffe 11 0",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    IRQ_PIN = 1'b1;
    repeat (5) tick();
    checks++;
    if (INT_REQ !== 1'b1 || INT_SRC !== 2'b11) begin
      failures++;
      $display("FAIL irq_held: got req=%b src=%b, want 1 11", INT_REQ, INT_SRC);
    end
    ack_pulse();
    checks++;
    if (INT_REQ !== 1'b0 || INT_SRC !== 2'b00) begin
      failures++;
      $display("FAIL irq_ack: got req=%b src=%b, want 0 00", INT_REQ, INT_SRC);
    end
    I_FLAG = 1'b1;
  endtask

  task automatic test_brk_irq();
    IRQ_PIN = 1'b0; I_FLAG = 1'b0;
    repeat (3) tick();
    BRK_REQ = 1'b1;
    boundary_pulse();
    BRK_REQ = 1'b0;
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFE, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL brk_first: got req=%b vec=%h src=%b b=%b, want 1 fffe 11 1",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    ack_pulse();
    checks++;
    if (INT_REQ !== 1'b0 || B_FLAG !== 1'b0) begin
      failures++;
      $display("FAIL brk_ack: got req=%b b=%b, want 0 0", INT_REQ, B_FLAG);
    end
    boundary_pulse();
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFE, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL irq_after_brk: got req=%b vec=%h src=%b b=%b, want 1 fffe 11 0",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    IRQ_PIN = 1'b1;
    ack_pulse();
    repeat (3) tick();
    boundary_pulse();
    checks++;
    if (INT_REQ !== 1'b0) begin
      failures++;
      $display("FAIL brk_cleared: got req=%b, want 0", INT_REQ);
    end
    I_FLAG = 1'b1;
  endtask

  task automatic test_priority();
    NMI_PIN = 1'b0; IRQ_PIN = 1'b0; I_FLAG = 1'b0;
    repeat (5) tick();
    boundary_pulse();
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFA, 2'b10, 1'b0}) begin
      failures++;
      $display("FAIL nmi_over_irq: got req=%b vec=%h src=%b b=%b, want 1 fffa 10 0",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    NMI_PIN = 1'b1;
    ack_pulse();
    boundary_pulse();
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFE, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL irq_after_nmi: got req=%b vec=%h src=%b b=%b, want 1 fffe 11 0",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    IRQ_PIN = 1'b1;
    ack_pulse();
    I_FLAG = 1'b1;
    repeat (4) tick();
    // NMI edge arriving while a BRK is pending
    BRK_REQ = 1'b1;
    boundary_pulse();
    BRK_REQ = 1'b0;
    NMI_PIN = 1'b0;
    repeat (5) tick();
`ifdef NMI_HIJACK_EN
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFA, 2'b10, 1'b1}) begin
      failures++;
      $display("FAIL hijack: got req=%b vec=%h src=%b b=%b, want 1 fffa 10 1",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    NMI_PIN = 1'b1;
    ack_pulse();
    boundary_pulse();
    checks++;
    if (INT_REQ !== 1'b0) begin
      failures++;
      $display("FAIL hijack_cleared: got req=%b, want 0", INT_REQ);
    end
`else
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFE, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL brk_not_hijacked: got req=%b vec=%h src=%b b=%b, want 1 fffe 11 1",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    NMI_PIN = 1'b1;
    ack_pulse();
    boundary_pulse();
    checks++;
    if ({INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b1, 16'hFFFA, 2'b10, 1'b0}) begin
      failures++;
      $display("FAIL nmi_after_brk: got req=%b vec=%h src=%b b=%b, want 1 fffa 10 0",
               INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    ack_pulse();
`endif
    repeat (3) tick();
  endtask

  task automatic test_res_pulse();
    logic bad;
    NMI_PIN = 1'b0;
    repeat (5) tick();
    #2 RES = 1'b0;
    #1;
    checks++;
    if ({CORE_RST_N, INT_REQ, INT_VEC, INT_SRC, B_FLAG} !== {1'b0, 1'b0, 16'hFFFC, 2'b01, 1'b0}) begin
      failures++;
      $display("FAIL res_async: got rst_n=%b req=%b vec=%h src=%b b=%b, want 0 0 fffc 01 0",
               CORE_RST_N, INT_REQ, INT_VEC, INT_SRC, B_FLAG);
    end
    NMI_PIN = 1'b1;
    repeat (3) tick();
    RES = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      if (CORE_RST_N !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL res_stretch: got rst_n=1 within hold window, want 0");
    end
    tick();
    checks++;
    if ({CORE_RST_N, INT_REQ, INT_SRC} !== {1'b1, 1'b1, 2'b01}) begin
      failures++;
      $display("FAIL res_release: got rst_n=%b req=%b src=%b, want 1 1 01", CORE_RST_N, INT_REQ, INT_SRC);
    end
    ack_pulse();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      INST_BOUNDARY = (i % 4 == 0);
      tick();
      if (INT_REQ !== 1'b0) bad = 1'b1;
    end
    INST_BOUNDARY = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL res_discard: got a request after reset vector, want none");
    end
  endtask

  task automatic test_random();
    bit          hn[SYNC+2];
    bit          hi[SYNC+2];
    bit          m_nmi, m_brk, m_req, m_b, fall, irq_on;
    logic [1:0]  m_src;
    logic [15:0] m_vec;
    do_reset();
    for (int j = 0; j < SYNC + 2; j++) begin
      hn[j] = 1'b1;
      hi[j] = 1'b1;
    end
    m_nmi = 0; m_brk = 0; m_req = 0; m_b = 0; m_src = 2'b00; m_vec = 16'hFFFC;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0) NMI_PIN = ~NMI_PIN;
      if ($urandom_range(0, 7) == 0) IRQ_PIN = ~IRQ_PIN;
      if ($urandom_range(0, 5) == 0) I_FLAG = ~I_FLAG;
      BRK_REQ       = ($urandom_range(0, 11) == 0);
      INST_BOUNDARY = ($urandom_range(0, 2) == 0);
      INT_ACK       = ($urandom_range(0, 2) == 0);
      // pin history: index 0 is the sample taken at the coming edge
      for (int j = SYNC + 1; j > 0; j--) begin
        hn[j] = hn[j-1];
        hi[j] = hi[j-1];
      end
      hn[0] = NMI_PIN;
      hi[0] = IRQ_PIN;
      fall   = !hn[SYNC] && hn[SYNC+1];
      irq_on = !hi[SYNC] && !I_FLAG;
      if (m_req) begin
        if (INT_ACK) begin
          if (m_src == 2'b10) m_nmi = 0;
          if (m_b) m_brk = 0;
          m_req = 0; m_src = 2'b00; m_b = 0;
        end
`ifdef NMI_HIJACK_EN
        else if (m_src == 2'b11 && m_nmi) begin
          m_src = 2'b10; m_vec = 16'hFFFA;
        end
`endif
      end else if (INST_BOUNDARY) begin
        if (m_nmi) begin
          m_req = 1; m_src = 2'b10; m_vec = 16'hFFFA; m_b = 0;
        end else if (m_brk || BRK_REQ) begin
          m_req = 1; m_src = 2'b11; m_vec = 16'hFFFE; m_b = 1;
        end else if (irq_on) begin
          m_req = 1; m_src = 2'b11; m_vec = 16'hFFFE; m_b = 0;
        end
      end
      if (fall) m_nmi = 1;
      if (BRK_REQ) m_brk = 1;
      tick();
      checks++;
      if ({CORE_RST_N, INT_REQ, INT_SRC, INT_VEC, B_FLAG} !== {1'b1, m_req, m_src, m_vec, m_b}) begin
        failures++;
        $display("FAIL random cycle %0d: got rst_n=%b req=%b src=%b vec=%h b=%b, want 1 %b %b %h %b",
                 c, CORE_RST_N, INT_REQ, INT_SRC, INT_VEC, B_FLAG, m_req, m_src, m_vec, m_b);
      end
    end
    BRK_REQ = 1'b0; INST_BOUNDARY = 1'b0; INT_ACK = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nmi();
    test_irq();
    test_brk_irq();
    test_priority();
    test_res_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
